// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial SHA-256 sequencer.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int W_WORD_DEF   = 32;
    localparam int N_ROUNDS_DEF = 64;
    localparam int N_LOAD_DEF   = 16;
    localparam int BCLK_DIV_DEF = 2;

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV and flags the falling toggle.
module bclk_gen
    import bit_serial_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic bclk,
    output logic fall_strobe
);

    localparam int DW = bits_for(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    // Strobe is combinational so the sequencer advances on the same edge bclk falls.
    assign tick        = en && !hold && (div_cnt == DIV_LAST);
    assign fall_strobe = tick && bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!hold) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_serial_seq.sv
// Bit-serial SHA-256 sequencer: bit clock, bit index and round count with start/busy/done.
// Optional freeze input enabled by defining BIT_SERIAL_HOLD_EN.
//
// state | meaning
// IDLE  | bclk and counters held at 0, waiting for start
// RUN   | bclk running, counter/round advance on each bclk fall
// DONE  | one-cycle done pulse, then back to IDLE
module bit_serial_seq
    import bit_serial_pkg::*;
#(
    parameter int W_WORD   = W_WORD_DEF,
    parameter int N_ROUNDS = N_ROUNDS_DEF,
    parameter int N_LOAD   = N_LOAD_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          bclk,
    output logic [bits_for(W_WORD)-1:0]   counter,
    output logic [bits_for(N_ROUNDS)-1:0] round,
    output logic                          load_phase,
    output logic                          word_last
`ifdef BIT_SERIAL_HOLD_EN
    ,
    input  logic                          hold
`endif
);

    localparam int CW = bits_for(W_WORD);
    localparam int RW = bits_for(N_ROUNDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(W_WORD - 1);
    localparam logic [RW-1:0] RND_LAST = RW'(N_ROUNDS - 1);

    seq_state_t state, state_nx;
    logic       hold_i;
    logic       fall_strobe;
    logic       cnt_last;
    logic       rnd_last;

`ifdef BIT_SERIAL_HOLD_EN
    assign hold_i = hold && (state == RUN);
`else
    assign hold_i = 1'b0;
`endif

    assign cnt_last = (counter == CNT_LAST);
    assign rnd_last = (round == RND_LAST);

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (state == RUN),
        .hold        (hold_i),
        .bclk        (bclk),
        .fall_strobe (fall_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fall_strobe && cnt_last && rnd_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        done       = (state == DONE);
        load_phase = (state != IDLE) && (int'(round) < N_LOAD);
        word_last  = (state != IDLE) && cnt_last;
    end

    // Counters move only on the bclk fall, so they are stable across every rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            round   <= '0;
        end else if (state != RUN) begin
            counter <= '0;
            round   <= '0;
        end else if (fall_strobe) begin
            if (cnt_last) begin
                counter <= '0;
                if (!rnd_last) begin
                    round <= round + 1'b1;
                end
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_seq.sv
// Scoreboard bench for bit_serial_seq: three configurations run side by side.
module tb_bit_serial_seq;
    import bit_serial_pkg::*;

    localparam int NDUT = 3;

    function automatic int cfg_w(input int g);
        case (g)
            0:       return 4;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_r(input int g);
        case (g)
            0:       return 2;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_nl(input int g);
        case (g)
            0:       return 1;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    logic            clk;
    logic            rst;
    logic            hold;
    logic [NDUT-1:0] start;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [NDUT-1:0] bclk;
    logic [NDUT-1:0] lp;
    logic [NDUT-1:0] wl;
    logic [NDUT-1:0] hold_v;
    logic [7:0]      cnt_x [NDUT];
    logic [7:0]      rnd_x [NDUT];

    assign hold_v = {2'b00, hold};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = cfg_w(g);
        localparam int R = cfg_r(g);
        logic [bits_for(W)-1:0] cnt;
        logic [bits_for(R)-1:0] rnd;

        bit_serial_seq #(
            .W_WORD   (W),
            .N_ROUNDS (R),
            .N_LOAD   (cfg_nl(g)),
            .BCLK_DIV (cfg_d(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .bclk       (bclk[g]),
            .counter    (cnt),
            .round      (rnd),
            .load_phase (lp[g]),
            .word_last  (wl[g])
`ifdef BIT_SERIAL_HOLD_EN
            ,
            .hold       (hold_v[g])
`endif
        );

        assign cnt_x[g] = 8'(cnt);
        assign rnd_x[g] = 8'(rnd);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [17:0] slot_q [NDUT][$];
    int          rise_q [NDUT][$];
    int          len_q  [NDUT][$];

    logic [NDUT-1:0] pb;
    logic [NDUT-1:0] pbusy;
    int              busy_len [NDUT];
    int              lvl_len  [NDUT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected slots follow directly from the block parameters.
    task automatic push_block(input int g, input int rise_cyc, input int extra);
        for (int r = 0; r < cfg_r(g); r++) begin
            for (int c = 0; c < cfg_w(g); c++) begin
                slot_q[g].push_back({8'(c), 8'(r), 1'(r < cfg_nl(g)), 1'(c == cfg_w(g) - 1)});
            end
        end
        rise_q[g].push_back(rise_cyc);
        len_q[g].push_back(cfg_w(g) * cfg_r(g) * 2 * cfg_d(g) + extra);
    endtask

    task automatic monitor();
        logic [17:0] obs;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("d%0d_done", g), 32'(done[g]), 32'(pbusy[g] && !busy[g]));
            if (busy[g] && !pbusy[g]) begin
                check($sformatf("d%0d_rise_expected", g), 32'(rise_q[g].size() > 0), 1);
                if (rise_q[g].size() > 0) check($sformatf("d%0d_busy_start_cyc", g), cyc, rise_q[g].pop_front());
                check($sformatf("d%0d_bclk_at_start", g), 32'(bclk[g]), 0);
                busy_len[g] = 0;
                lvl_len[g]  = 0;
            end
            if (busy[g]) begin
                busy_len[g]++;
                if (pbusy[g] && (bclk[g] != pb[g])) begin
                    check($sformatf("d%0d_level_len", g), lvl_len[g], cfg_d(g));
                    lvl_len[g] = 1;
                end else if (!hold_v[g]) begin
                    lvl_len[g]++;
                end
                if (bclk[g] && !pb[g]) begin
                    check($sformatf("d%0d_slot_expected", g), 32'(slot_q[g].size() > 0), 1);
                    if (slot_q[g].size() > 0) begin
                        obs = {cnt_x[g], rnd_x[g], lp[g], wl[g]};
                        check($sformatf("d%0d_slot", g), 32'(obs), 32'(slot_q[g].pop_front()));
                    end
                end
            end else begin
                check($sformatf("d%0d_idle_bclk", g), 32'(bclk[g]), 0);
                check($sformatf("d%0d_idle_counter", g), 32'(cnt_x[g]), 0);
                check($sformatf("d%0d_idle_word_last", g), 32'(wl[g]), 0);
                if (!done[g]) begin
                    check($sformatf("d%0d_idle_round", g), 32'(rnd_x[g]), 0);
                    check($sformatf("d%0d_idle_load_phase", g), 32'(lp[g]), 0);
                end
            end
            if (!busy[g] && pbusy[g]) begin
                check($sformatf("d%0d_last_level_len", g), lvl_len[g], cfg_d(g));
                check($sformatf("d%0d_len_expected", g), 32'(len_q[g].size() > 0), 1);
                if (len_q[g].size() > 0) check($sformatf("d%0d_busy_len", g), busy_len[g], len_q[g].pop_front());
            end
            pb[g]    = bclk[g];
            pbusy[g] = busy[g];
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic drain(input int budget);
        int pending;
        for (int n = 0; n < budget; n++) begin
            pending = 0;
            for (int g = 0; g < NDUT; g++) begin
                pending += slot_q[g].size() + rise_q[g].size() + len_q[g].size() + int'(busy[g]) + int'(done[g]);
            end
            if (pending == 0) break;
            step();
        end
        pending = 0;
        for (int g = 0; g < NDUT; g++) begin
            pending += slot_q[g].size() + rise_q[g].size() + len_q[g].size() + int'(busy[g]);
        end
        check("drain_timeout", pending, 0);
    endtask

    task automatic check_all_zero(input int g, input string phase);
        check($sformatf("%s_d%0d_busy", phase, g), 32'(busy[g]), 0);
        check($sformatf("%s_d%0d_done", phase, g), 32'(done[g]), 0);
        check($sformatf("%s_d%0d_bclk", phase, g), 32'(bclk[g]), 0);
        check($sformatf("%s_d%0d_counter", phase, g), 32'(cnt_x[g]), 0);
        check($sformatf("%s_d%0d_round", phase, g), 32'(rnd_x[g]), 0);
        check($sformatf("%s_d%0d_load_phase", phase, g), 32'(lp[g]), 0);
        check($sformatf("%s_d%0d_word_last", phase, g), 32'(wl[g]), 0);
    endtask

    initial begin
        logic saved_bclk;
        logic [7:0] saved_cnt;
        rst   = 1'b1;
        start = '0;
        hold  = 1'b0;
        pb    = '0;
        pbusy = '0;
        for (int g = 0; g < NDUT; g++) begin
            busy_len[g] = 0;
            lvl_len[g]  = 0;
        end
        repeat (3) step();
        for (int g = 0; g < NDUT; g++) check_all_zero(g, "reset");
        rst = 1'b0;
        step();

        // All three configurations from a single simultaneous start pulse.
        start = '1;
        for (int g = 0; g < NDUT; g++) push_block(g, cyc + 1, 0);
        step();
        start = '0;
        drain(200);

        // Asynchronous reset in the middle of a run, then a clean rerun.
        start[0] = 1'b1;
        push_block(0, cyc + 1, 0);
        step();
        start[0] = 1'b0;
        repeat (6) step();
        check("pre_rst_counter", 32'(cnt_x[0]), 3);
        check("pre_rst_word_last", 32'(wl[0]), 1);
        #2 rst = 1'b1;
        #1 check_all_zero(0, "async_rst");
        slot_q[0].delete();
        rise_q[0].delete();
        len_q[0].delete();
        pb    = '0;
        pbusy = '0;
        step();
        rst = 1'b0;
        step();
        start[0] = 1'b1;
        push_block(0, cyc + 1, 0);
        step();
        start[0] = 1'b0;
        drain(100);

        // start held high: DONE and one IDLE cycle separate the two blocks.
        start[0] = 1'b1;
        push_block(0, cyc + 1, 0);
        push_block(0, cyc + 1 + 16 + 2, 0);
        repeat (19) step();
        start[0] = 1'b0;
        drain(100);

`ifdef BIT_SERIAL_HOLD_EN
        start[0] = 1'b1;
        push_block(0, cyc + 1, 5);
        step();
        start[0] = 1'b0;
        repeat (5) step();
        saved_bclk = bclk[0];
        saved_cnt  = cnt_x[0];
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_bclk_frozen", 32'(bclk[0]), 32'(saved_bclk));
            check("hold_counter_frozen", 32'(cnt_x[0]), 32'(saved_cnt));
            check("hold_busy", 32'(busy[0]), 1);
        end
        hold = 1'b0;
        drain(100);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
